// File: rtl/x_top_rv32i_rf_pkg.sv
// Shared constants and state type for the RV32I register-file port sequencer.
package x_top_rv32i_rf_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned XLEN   = 2 * HALF_W;

  typedef enum logic [2:0] {
    IDLE,
    RS1,
    RS2,
    CAP,
    WR,
    INIT
  } rf_state_t;

endpackage

// File: rtl/x_top_rv32i_rf_ctrl.sv
// Register-file port sequencer: serialises rs1/rs2 reads and rd writes onto one
// single-port RAM made of two 16-bit banks (lo = bits 15:0, hi = bits 31:16).
// x0 reads as zero and writes to x0 are dropped.
// Optional: define X_TOP_RV32I_RF_ZERO_INIT_EN to zero all 32 entries after reset.
module x_top_rv32i_rf_ctrl #(
  parameter int unsigned ADDR_W = x_top_rv32i_rf_pkg::ADDR_W,
  parameter int unsigned HALF_W = x_top_rv32i_rf_pkg::HALF_W,
  localparam int unsigned XLEN  = 2 * HALF_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_ready,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_rs_valid,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_ram_wnr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [HALF_W-1:0] o_ram_wdata_lo,
  output logic [HALF_W-1:0] o_ram_wdata_hi,
  input  logic [HALF_W-1:0] i_ram_rdata_lo,
  input  logic [HALF_W-1:0] i_ram_rdata_hi
);

  import x_top_rv32i_rf_pkg::*;

  rf_state_t         state_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  // rs1 word is parked here so both outputs update together with o_rs_valid.
  logic [XLEN-1:0]   rs1_cap_q;
  logic [XLEN-1:0]   ram_word;

`ifdef X_TOP_RV32I_RF_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_cnt_q;
`endif

  assign ram_word = {i_ram_rdata_hi, i_ram_rdata_lo};

  // Requests are only taken in IDLE.
  assign o_ready = (state_q == IDLE);

  // Sequencer FSM with registered RAM-side and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rs_valid     <= 1'b0;
      o_rs1_data     <= '0;
      o_rs2_data     <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rs1_cap_q      <= '0;
      o_ram_addr     <= '0;
      o_ram_wdata_lo <= '0;
      o_ram_wdata_hi <= '0;
`ifdef X_TOP_RV32I_RF_ZERO_INIT_EN
      // First INIT cycle must already present the write of entry 0.
      state_q        <= INIT;
      init_cnt_q     <= '0;
      o_ram_wnr      <= 1'b1;
`else
      state_q        <= IDLE;
      o_ram_wnr      <= 1'b0;
`endif
    end else begin
      o_rs_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          o_ram_wnr <= 1'b0;
          // Write wins a tie so a held read always sees the new value.
          if (i_wr_req) begin
            if (i_rd != '0) begin
              state_q        <= WR;
              o_ram_wnr      <= 1'b1;
              o_ram_addr     <= i_rd;
              o_ram_wdata_lo <= i_wdata[HALF_W-1:0];
              o_ram_wdata_hi <= i_wdata[XLEN-1:HALF_W];
            end
          end else if (i_rd_req) begin
            state_q    <= RS1;
            rs1_q      <= i_rs1;
            rs2_q      <= i_rs2;
            o_ram_addr <= i_rs1;
          end
        end
        RS1: begin
          state_q    <= RS2;
          o_ram_addr <= rs2_q;
        end
        RS2: begin
          state_q   <= CAP;
          rs1_cap_q <= (rs1_q == '0) ? '0 : ram_word;
        end
        CAP: begin
          state_q    <= IDLE;
          o_rs1_data <= rs1_cap_q;
          o_rs2_data <= (rs2_q == '0) ? '0 : ram_word;
          o_rs_valid <= 1'b1;
        end
        WR: begin
          state_q   <= IDLE;
          o_ram_wnr <= 1'b0;
        end
`ifdef X_TOP_RV32I_RF_ZERO_INIT_EN
        INIT: begin
          o_ram_wdata_lo <= '0;
          o_ram_wdata_hi <= '0;
          if (init_cnt_q == '1) begin
            state_q   <= IDLE;
            o_ram_wnr <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
            o_ram_addr <= init_cnt_q + 1'b1;
            o_ram_wnr  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q   <= IDLE;
          o_ram_wnr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_top_rv32i_rf_ctrl.sv
// Self-checking bench for x_top_rv32i_rf_ctrl: behavioural two-bank RAM, an
// architectural register-file model with request/latency bookkeeping, a per-cycle
// compare process, directed literal checks and a randomized phase.
`timescale 1ns/1ps
module tb_x_top_rv32i_rf_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_ready;
  logic        i_rd_req;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        i_wr_req;
  logic [4:0]  i_rd;
  logic [31:0] i_wdata;
  logic        o_rs_valid;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        o_ram_wnr;
  logic [4:0]  o_ram_addr;
  logic [15:0] o_ram_wdata_lo;
  logic [15:0] o_ram_wdata_hi;
  logic [15:0] i_ram_rdata_lo;
  logic [15:0] i_ram_rdata_hi;

  always #5 i_clk = ~i_clk;

  x_top_rv32i_rf_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_ready        (o_ready),
    .i_rd_req       (i_rd_req),
    .i_rs1          (i_rs1),
    .i_rs2          (i_rs2),
    .i_wr_req       (i_wr_req),
    .i_rd           (i_rd),
    .i_wdata        (i_wdata),
    .o_rs_valid     (o_rs_valid),
    .o_rs1_data     (o_rs1_data),
    .o_rs2_data     (o_rs2_data),
    .o_ram_wnr      (o_ram_wnr),
    .o_ram_addr     (o_ram_addr),
    .o_ram_wdata_lo (o_ram_wdata_lo),
    .o_ram_wdata_hi (o_ram_wdata_hi),
    .i_ram_rdata_lo (i_ram_rdata_lo),
    .i_ram_rdata_hi (i_ram_rdata_hi)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Power-up RAM contents, shared by the RAM and the model as "unwritten" values.
  logic [31:0] seed [32];
  initial for (int i = 0; i < 32; i++) seed[i] = $urandom;

  // Behavioural RAM: two banks, one address, registered read data.
  logic [15:0] mem_lo [32];
  logic [15:0] mem_hi [32];
  bit          mem_wr [32];
  int          wr_count = 0;
  logic [4:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge i_clk) begin
    if (o_ram_wnr === 1'b1) begin
      mem_lo[o_ram_addr] <= o_ram_wdata_lo;
      mem_hi[o_ram_addr] <= o_ram_wdata_hi;
      mem_wr[o_ram_addr] <= 1'b1;
      // Garbage on the read bus when not reading.
      i_ram_rdata_lo     <= 16'($urandom);
      i_ram_rdata_hi     <= 16'($urandom);
      if (!i_rst) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= o_ram_addr;
        last_wr_data <= {o_ram_wdata_hi, o_ram_wdata_lo};
      end
    end else begin
      i_ram_rdata_lo <= mem_wr[o_ram_addr] ? mem_lo[o_ram_addr] : seed[o_ram_addr][15:0];
      i_ram_rdata_hi <= mem_wr[o_ram_addr] ? mem_hi[o_ram_addr] : seed[o_ram_addr][31:16];
    end
  end

  // Architectural model: register values plus cycle bookkeeping of busy time.
  logic [31:0] ref_rf [32];
  bit          ref_wr [32];
  int          busy      = 0;
  int          rd_left   = 0;
  bit          init_mode = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_wnr   = 1'b0;
  logic [4:0]  exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rs1   = '0;
  logic [31:0] exp_rs2   = '0;
  logic [31:0] pend1     = '0;
  logic [31:0] pend2     = '0;
  int          n_rd_acc  = 0;
  int          n_wr_acc  = 0;

  function automatic logic [31:0] ref_val(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    return ref_wr[a] ? ref_rf[a] : seed[a];
  endfunction

  always @(posedge i_clk) begin
    bit was_ready;
    cyc++;
    if (i_rst) begin
      busy      = 0;
      rd_left   = 0;
      exp_valid = 1'b0;
      exp_rs1   = '0;
      exp_rs2   = '0;
      exp_wnr   = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
`ifdef X_TOP_RV32I_RF_ZERO_INIT_EN
      busy      = 32;
      init_mode = 1'b1;
      exp_wnr   = 1'b1;
      for (int i = 0; i < 32; i++) begin
        ref_rf[i] = '0;
        ref_wr[i] = 1'b1;
      end
`endif
    end else begin
      was_ready = (busy == 0);
      exp_valid = 1'b0;
      exp_wnr   = 1'b0;
      if (rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) begin
          exp_valid = 1'b1;
          exp_rs1   = pend1;
          exp_rs2   = pend2;
        end
      end
      if (busy > 0) busy--;
      if (init_mode) begin
        if (busy > 0) begin
          exp_wnr   = 1'b1;
          exp_addr  = 5'(32 - busy);
          exp_wdata = '0;
        end else begin
          init_mode = 1'b0;
        end
      end else if (was_ready && i_wr_req) begin
        n_wr_acc++;
        if (i_rd != 5'd0) begin
          busy         = 1;
          exp_wnr      = 1'b1;
          exp_addr     = i_rd;
          exp_wdata    = i_wdata;
          ref_rf[i_rd] = i_wdata;
          ref_wr[i_rd] = 1'b1;
        end
      end else if (was_ready && i_rd_req) begin
        n_rd_acc++;
        busy    = 3;
        rd_left = 3;
        pend1   = ref_val(i_rs1);
        pend2   = ref_val(i_rs2);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (cyc > 0) begin
      chk("ready", 32'(o_ready), 32'(busy == 0));
      chk("rs_valid", 32'(o_rs_valid), 32'(exp_valid));
      chk("rs1_data", o_rs1_data, exp_rs1);
      chk("rs2_data", o_rs2_data, exp_rs2);
      chk("ram_wnr", 32'(o_ram_wnr), 32'(exp_wnr));
      if (exp_wnr) begin
        chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
        chk("ram_wdata_lo", 32'(o_ram_wdata_lo), 32'(exp_wdata[15:0]));
        chk("ram_wdata_hi", 32'(o_ram_wdata_hi), 32'(exp_wdata[31:16]));
      end
    end
  end

  task automatic wait_wr_acc(input string name);
    int start;
    bit ok;
    start = n_wr_acc;
    ok    = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      if (n_wr_acc != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_rd_acc(input string name);
    int start;
    bit ok;
    start = n_rd_acc;
    ok    = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      if (n_rd_acc != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Returns cycles from the first post-accept cycle to the valid pulse (-1 on timeout).
  task automatic wait_valid(input string name, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (o_rs_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge i_clk);
    end
    chk(name, 32'(lat >= 0), 32'd1);
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] d);
    i_wr_req = 1'b1;
    i_rd     = rd;
    i_wdata  = d;
    wait_wr_acc("wr_accept");
    i_wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b, output int lat);
    i_rd_req = 1'b1;
    i_rs1    = a;
    i_rs2    = b;
    wait_rd_acc("rd_accept");
    i_rd_req = 1'b0;
    wait_valid("rd_valid", lat);
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int lat;
    int wc;
    int n;
    int pulses[$];

    i_rst    = 1'b1;
    i_rd_req = 1'b0;
    i_wr_req = 1'b0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_rd     = '0;
    i_wdata  = '0;
    repeat (3) @(negedge i_clk);

    // Reset state.
    chk("rst_valid", 32'(o_rs_valid), 32'd0);
    chk("rst_rs1", o_rs1_data, 32'h0);
    chk("rst_rs2", o_rs2_data, 32'h0);
    chk("rst_addr", 32'(o_ram_addr), 32'd0);
    chk("rst_wdata_lo", 32'(o_ram_wdata_lo), 32'd0);
`ifdef X_TOP_RV32I_RF_ZERO_INIT_EN
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_wnr", 32'(o_ram_wnr), 32'd1);
    i_rst = 1'b0;
    wc = wr_count;
    n  = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_ready === 1'b1) break;
      n++;
      @(negedge i_clk);
    end
    chk("init_busy_cycles", 32'(n), 32'd32);
    chk("init_write_count", 32'(wr_count - wc), 32'd32);
    do_read(5'd31, 5'd17, lat);
    chk("init_rs1_x31", o_rs1_data, 32'h0);
    chk("init_rs2_x17", o_rs2_data, 32'h0);
`else
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_wnr", 32'(o_ram_wnr), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
`endif

    // Write then read the same register.
    do_write(5'd5, 32'hDEAD_BEEF);
    do_read(5'd5, 5'd5, lat);
    chk("wr_addr", 32'(last_wr_addr), 32'd5);
    chk("wr_lo", 32'(last_wr_data[15:0]), 32'h0000_BEEF);
    chk("wr_hi", 32'(last_wr_data[31:16]), 32'h0000_DEAD);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_x5_rs1", o_rs1_data, 32'hDEAD_BEEF);
    chk("rd_x5_rs2", o_rs2_data, 32'hDEAD_BEEF);

    // x0 is hardwired.
    wc = wr_count;
    do_write(5'd0, 32'h1234_5678);
    repeat (3) @(negedge i_clk);
    chk("x0_no_write", 32'(wr_count), 32'(wc));
    do_read(5'd0, 5'd0, lat);
    chk("x0_rs1", o_rs1_data, 32'h0);
    chk("x0_rs2", o_rs2_data, 32'h0);

    // Simultaneous write and read: write first, held read sees it.
    i_wr_req = 1'b1;
    i_rd     = 5'd7;
    i_wdata  = 32'h0000_00AA;
    i_rd_req = 1'b1;
    i_rs1    = 5'd7;
    i_rs2    = 5'd3;
    n        = n_rd_acc;
    wait_wr_acc("sim_wr_accept");
    i_wr_req = 1'b0;
    chk("sim_rd_not_first", 32'(n_rd_acc - n), 32'd0);
    wait_rd_acc("sim_rd_accept");
    i_rd_req = 1'b0;
    wait_valid("sim_valid", lat);
    chk("sim_rs1", o_rs1_data, 32'h0000_00AA);

    // Back-to-back reads, starting in the valid cycle of the previous read.
    i_rd_req = 1'b1;
    i_rs1    = 5'd5;
    i_rs2    = 5'd7;
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_clk);
      if (o_rs_valid === 1'b1) pulses.push_back(k);
    end
    i_rd_req = 1'b0;
    chk("b2b_pulses", 32'(pulses.size()), 32'd4);
    for (int i = 1; i < pulses.size(); i++) chk("b2b_spacing", 32'(pulses[i] - pulses[i-1]), 32'd4);
    chk("b2b_rs1", o_rs1_data, 32'hDEAD_BEEF);
    chk("b2b_rs2", o_rs2_data, 32'h0000_00AA);

    // Reset in the RS2 cycle of a read.
    @(negedge i_clk);
    i_rd_req = 1'b1;
    i_rs1    = 5'd5;
    i_rs2    = 5'd5;
    wait_rd_acc("mid_rd_accept");
    i_rd_req = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid_rst_valid", 32'(o_rs_valid), 32'd0);
    chk("mid_rst_rs1", o_rs1_data, 32'h0);
    chk("mid_rst_rs2", o_rs2_data, 32'h0);
`ifndef X_TOP_RV32I_RF_ZERO_INIT_EN
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
`endif
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_rs_valid === 1'b1) n++;
    end
    chk("mid_rst_no_pulse", 32'(n), 32'd0);
    wait_ready("mid_rst_ready_back");

    // Randomized traffic, occasional resets; the compare process does the checking.
    for (int it = 0; it < 800; it++) begin
      i_rst    = ($urandom_range(0, 99) == 0);
      i_wr_req = ($urandom_range(0, 3) == 0);
      i_rd_req = ($urandom_range(0, 1) == 1);
      i_rd     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      i_rs1    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      i_rs2    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      i_wdata  = $urandom;
      @(negedge i_clk);
    end
    i_rst    = 1'b0;
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    repeat (40) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_top_rv32i_rf_ctrl.md
Name: x_top_rv32i_rf_ctrl

Overview:
Sequencer between the RV32I core's decode/writeback stages and the register-file RAM.
- Storage is two 16-bit x 32-entry single-port synchronous RAM banks, lo = bits 15:0 and hi = bits 31:16.
- The banks share one address and one write/not-read strobe, and have 1-cycle registered read data.
- The block serialises rs1/rs2 reads and rd writes onto that single port.
- It hardwires x0 to zero.

Parameters:
ADDR_W, 5, register index width (32 registers)
HALF_W, 16, RAM bank data width; XLEN = 2*HALF_W

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
o_ready  out  1  high when a request can be accepted (state IDLE)
i_rd_req  in  1  read request; accepted on i_rd_req & o_ready
i_rs1  in  ADDR_W  first source index
i_rs2  in  ADDR_W  second source index
i_wr_req  in  1  write request; accepted on i_wr_req & o_ready
i_rd  in  ADDR_W  destination index
i_wdata  in  XLEN  write data
o_rs_valid  out  1  1-cycle pulse: o_rs1_data/o_rs2_data updated
o_rs1_data  out  XLEN  rs1 value, held until next o_rs_valid
o_rs2_data  out  XLEN  rs2 value, held until next o_rs_valid
o_ram_wnr  out  1  1 = write, 0 = read
o_ram_addr  out  ADDR_W  RAM address (both banks)
o_ram_wdata_lo  out  HALF_W  write data to lo bank
o_ram_wdata_hi  out  HALF_W  write data to hi bank
i_ram_rdata_lo  in  HALF_W  lo bank read data (valid the cycle after address presented)
i_ram_rdata_hi  in  HALF_W  hi bank read data

Behaviour:
- Reset values:
  - state = IDLE; o_rs_valid = 0; o_rs1_data = o_rs2_data = 0.
  - o_ram_wnr = 0, o_ram_addr = 0, o_ram_wdata_lo/hi = 0.
  - o_ready = 1 (it is decoded from state).
- States: IDLE, RS1, RS2, CAP, WR (plus INIT under the optional feature).
- Accept (IDLE only):
  - Both requests high: the write is accepted and the read is not. The requester holds i_rd_req, and it is accepted on a later IDLE cycle.
  - This guarantees the read observes the write.
  - Indices and data are registered at accept.
- Read sequence, accept at edge E0:
  - RS1: o_ram_addr = rs1, wnr = 0.
  - E1 -> RS2: addr = rs2; RAM data = rs1 word.
  - E2 -> capture rs1 = {hi, lo} -> CAP; RAM data = rs2 word.
  - E3 -> capture rs2, o_rs_valid = 1 for one cycle, -> IDLE.
  - Latency from accept to valid is 3 cycles. A new request may be accepted in the valid cycle.
- x0 read: if a registered index == 0, the captured value is forced to 32'h0 regardless of RAM data.
- Write sequence, accept at E0:
  - If rd != 0: state WR drives wnr = 1, addr = rd, wdata_lo = wdata[15:0], wdata_hi = wdata[31:16]; E1 -> IDLE.
  - If rd == 0: the write is dropped, state stays IDLE, o_ram_wnr never asserts. Accept is still consumed in 1 cycle.
- o_ram_wnr is high only in WR/INIT, never during a read state.
- Reset mid-operation:
  - Returns to IDLE next edge with no o_rs_valid pulse and o_ram_wnr = 0.
  - An accepted but unissued write is lost.
  - o_rs1/2_data clear to 0.
- Read data outside the capture cycles is don't-care and must not reach the outputs.

Optional Feature:
Macro X_TOP_RV32I_RF_ZERO_INIT_EN.
- Defined:
  - After reset, enter INIT.
  - A 5-bit counter writes 0 to addresses 0..31, one per cycle (wnr = 1, both banks).
  - Then IDLE.
  - o_ready = 0 for exactly 32 cycles after reset deassertion.
  - Reset during INIT restarts the count at 0.
- Undefined: IDLE immediately after reset; RAM contents unspecified until written (x in simulation). Only x0 reads are guaranteed to return 0.

Decomposition:
- Package x_top_rv32i_rf_pkg holds:
  - constants ADDR_W, HALF_W, XLEN;
  - typedef enum rf_state_t {IDLE, RS1, RS2, CAP, WR, INIT}.
- No sub-module. FSM, capture registers and init counter stay in one module.
- The RAM banks are instantiated by the parent.

Test Plan:
- Write then read, with a behavioural RAM model for both banks:
  - Stimulus: write x5 = 32'hDEAD_BEEF, then read rs1 = 5, rs2 = 5.
  - Required: RAM sees wnr = 1, addr = 5, lo = 16'hBEEF, hi = 16'hDEAD.
  - Required: o_rs_valid 3 cycles after read accept; both data = 32'hDEAD_BEEF.
- x0 hardwiring: write x0 = 32'h1234_5678 -> o_ram_wnr never 1. Read rs1 = 0, rs2 = 0 -> both 32'h0.
- Simultaneous requests:
  - Stimulus: i_wr_req (x7 = 32'h0000_00AA) and i_rd_req (rs1 = 7, rs2 = 3) in the same cycle.
  - Required: write accepted first; held read later returns rs1 = 32'h0000_00AA.
- Back-to-back:
  - Stimulus: read accepted in the o_rs_valid cycle of the previous read.
  - Required: o_rs_valid pulses every 4 cycles; no duplicate or missing pulses.
- Reset mid-read: assert i_rst at the RS2 cycle -> no o_rs_valid, data = 0, o_ready = 1 after the reset edge.
- Optional feature, with X_TOP_RV32I_RF_ZERO_INIT_EN defined:
  - o_ready = 0 for 32 cycles with addrs 0..31 written to 0.
  - Then reading rs1 = 31, rs2 = 17 returns 0 and 0.
